// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the rsa_modexp engine.
// Build option: RSA_MODEXP_CONST_TIME_EN (consumed by rsa_modexp) selects fixed-latency exponentiation.
package rsa_pkg;

    localparam int RSA_WIDTH   = 32;
    localparam int ITER_CYCLES = RSA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REDUCE,
        S_SQUARE,
        S_MULT,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, one multiplier bit per cycle, MSB first.
// Requires a < n; the running partial product stays below n so no full-width product is formed.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH+1:0] part;
    logic [WIDTH+1:0] a_r;
    logic [WIDTH+1:0] n_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH+1:0] dbl;
    logic [WIDTH+1:0] sum;

    // Two extra bits hold 2P and P+a, both below 2n, before the conditional subtract.
    always_comb begin
        dbl = part + part;
        if (dbl >= n_r) dbl = dbl - n_r;
        sum = dbl + (b_r[WIDTH-1] ? a_r : '0);
        if (sum >= n_r) sum = sum - n_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            part <= '0;
            a_r  <= '0;
            n_r  <= '0;
            b_r  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                part <= '0;
                a_r  <= {2'b00, a};
                n_r  <= {2'b00, n};
                b_r  <= b;
                cnt  <= CW'(WIDTH - 1);
                run  <= 1'b1;
            end else if (run) begin
                part <= sum;
                b_r  <= {b_r[WIDTH-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = part[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation: result = base^exp mod modulus.
// Build option: RSA_MODEXP_CONST_TIME_EN runs the multiply step for every exponent bit (fixed latency).
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_p;
    logic             mm_done;
    logic             bit_set;

    assign bit_set = exp_r[idx];

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (mod_r),
        .p     (mm_p),
        .done  (mm_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            base_r   <= '0;
            exp_r    <= '0;
            mod_r    <= '0;
            acc      <= '0;
            idx      <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
        end else begin
            done     <= 1'b0;
            mm_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r <= base;
                        exp_r  <= exp;
                        mod_r  <= modulus;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mod_r < WIDTH'(2)) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        // base*1 mod n brings an oversized base into range for later multiplies.
                        acc      <= WIDTH'(1);
                        idx      <= IW'(WIDTH - 1);
                        mm_start <= 1'b1;
                        mm_a     <= WIDTH'(1);
                        mm_b     <= base_r;
                        state    <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (mm_done) begin
                        base_r   <= mm_p;
                        mm_start <= 1'b1;
                        mm_a     <= acc;
                        mm_b     <= acc;
                        state    <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    if (mm_done) begin
                        acc <= mm_p;
`ifdef RSA_MODEXP_CONST_TIME_EN
                        mm_start <= 1'b1;
                        mm_a     <= base_r;
                        mm_b     <= mm_p;
                        state    <= S_MULT;
`else
                        if (bit_set) begin
                            mm_start <= 1'b1;
                            mm_a     <= base_r;
                            mm_b     <= mm_p;
                            state    <= S_MULT;
                        end else begin
                            state <= S_NEXT;
                        end
`endif
                    end
                end
                S_MULT: begin
                    if (mm_done) begin
`ifdef RSA_MODEXP_CONST_TIME_EN
                        if (bit_set) acc <= mm_p;
`else
                        acc <= mm_p;
`endif
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == '0) begin
                        result <= acc;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        idx      <= idx - 1'b1;
                        mm_start <= 1'b1;
                        mm_a     <= acc;
                        mm_b     <= acc;
                        state    <= S_SQUARE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp: right-to-left reference exponentiation plus per-cycle output monitor.
// Honours RSA_MODEXP_CONST_TIME_EN for the expected latency.
module tb_rsa_modexp;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base = '0;
    logic [W-1:0] exp = '0;
    logic [W-1:0] modulus = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .exp     (exp),
        .modulus (modulus),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W:0]   exp_q[$];   // {err, result} per accepted request
    logic [W:0]   mon_e;
    logic [W-1:0] held = '0;
    bit           mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model_pow(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input logic [W-1:0] m);
        longint unsigned r;
        longint unsigned x;
        longint unsigned mm;
        if (m < 2) return '0;
        mm = 64'(m);
        r  = 1;
        x  = 64'(b) % mm;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W-1:0];
    endfunction

    // Cycles spanned from the start-sample cycle through the done cycle, both inclusive.
    function automatic int model_latency(input logic [W-1:0] e, input logic [W-1:0] m);
        int k;
        if (m < 2) return 3;
`ifdef RSA_MODEXP_CONST_TIME_EN
        k = 1 + 2 * W;
`else
        k = 1 + W + $countones(e);
`endif
        return 3 + k * (W + 2) + W;
    endfunction

    // Every cycle: done must match the next expectation, otherwise result must hold.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (rst) begin
                held = '0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", result, mon_e[W-1:0]);
                    check("err", err, mon_e[W]);
                end
                held = result;
            end else begin
                check("result_hold", result, held);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          input bit inject, output int lat);
        int n;
        bit seen;
        bit busy_bad;
        exp_q.push_back({(m < 2), model_pow(b, e, m)});
        repeat (2) @(negedge clk);
        base = b; exp = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base = $urandom; exp = $urandom; modulus = $urandom;
        n = 0; seen = 1'b0; busy_bad = 1'b0; lat = 0;
        while (!seen && n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1 && m >= 2) check("err_clear", err, 1'b0);
            if (done) begin
                seen = 1'b1;
                if (busy) busy_bad = 1'b1;
            end else if (!busy) begin
                busy_bad = 1'b1;
            end
            start = (inject && n == 100);
            if (start) begin
                base = $urandom; exp = $urandom; modulus = 32'd7;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("timeout", 1'b0, 1'b1);
            exp_q.delete();
        end else begin
            lat = n + 2;
            check("latency", lat, model_latency(e, m));
            check("busy", busy_bad, 1'b0);
        end
    endtask

    logic [W-1:0] tb_b[12] = '{32'd4, 32'd65, 32'd2790, 32'd500, 32'd7, 32'd65, 32'd65,
                               32'h12345678, 32'd9, 32'd9, 32'd3, 32'hFFFFFFFF};
    logic [W-1:0] tb_e[12] = '{32'd13, 32'd17, 32'd413, 32'd13, 32'd0, 32'd1, 32'hFFFFFFFF,
                               32'hDEADBEEF, 32'd5, 32'd5, 32'd5, 32'd3};
    logic [W-1:0] tb_m[12] = '{32'd497, 32'd3233, 32'd3233, 32'd497, 32'd497, 32'd3233, 32'd3233,
                               32'hFFFFFFFB, 32'd1, 32'd0, 32'd7, 32'hFFFFFFFF};

    initial begin
        int lat;
        int cnt;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);
        check("reset_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Hand-computed values pin the reference model.
        check("pin_4_13_497", model_pow(32'd4, 32'd13, 32'd497), 32'd445);
        check("pin_65_17_3233", model_pow(32'd65, 32'd17, 32'd3233), 32'd2790);
        check("pin_2790_413_3233", model_pow(32'd2790, 32'd413, 32'd3233), 32'd65);
        check("pin_500_13_497", model_pow(32'd500, 32'd13, 32'd497), 32'd444);
        check("pin_exp0", model_pow(32'd7, 32'd0, 32'd497), 32'd1);
`ifdef RSA_MODEXP_CONST_TIME_EN
        check("pin_lat_e1", model_latency(32'd1, 32'd3233), 2245);
        check("pin_lat_eff", model_latency(32'hFFFFFFFF, 32'd3233), 2245);
`else
        check("pin_lat_13", model_latency(32'd13, 32'd497), 1259);
        check("pin_lat_e1", model_latency(32'd1, 32'd3233), 1191);
`endif

        for (int i = 0; i < 12; i++) begin
            run_op(tb_b[i], tb_e[i], tb_m[i], 1'b0, lat);
`ifdef RSA_MODEXP_CONST_TIME_EN
            if (i == 5 || i == 6) check("ct_latency", lat, 2245);
`endif
        end

        // Abort mid-SQUARE: result from the previous request is nonzero before reset.
        run_op(32'd4, 32'd13, 32'd497, 1'b0, lat);
        exp_q.push_back({1'b0, model_pow(32'd4, 32'd13, 32'd497)});
        repeat (2) @(negedge clk);
        base = 32'd4; exp = 32'd13; modulus = 32'd497; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, '0);
        check("abort_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (2500) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("abort_no_done", cnt, 0);

        // A start pulse while busy must be ignored.
        run_op(32'd65, 32'd17, 32'd3233, 1'b1, lat);
        cnt = 0;
        repeat (1400) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("ignored_start", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
